// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider for the execute stage.
// Returns {remainder, quotient}. Signed mode divides magnitudes, then fixes signs.
module ex_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned WW = 2 * WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     work_q, work_d;
    logic [W-1:0]      divisor_q, divisor_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [2*W-1:0]    result_q, result_d;
    logic              ready_q, ready_d;

    logic [W-1:0]      dividend_mag;
    logic [W-1:0]      divisor_mag;
    logic [W:0]        diff;
    logic [W-1:0]      quo_raw;
    logic [W-1:0]      rem_raw;
    logic [W-1:0]      quo_fix;
    logic [W-1:0]      rem_fix;

    // Operand magnitudes, trial subtraction and sign-corrected results.
    always_comb begin
        dividend_mag = (signed_div_i && opdata1_i[W-1]) ? (W'(0) - opdata1_i) : opdata1_i;
        divisor_mag  = (signed_div_i && opdata2_i[W-1]) ? (W'(0) - opdata2_i) : opdata2_i;
        diff         = {1'b0, work_q[2*W-1:W]} - {1'b0, divisor_q};
        quo_raw      = work_q[W-1:0];
        rem_raw      = work_q[2*W:W+1];
        quo_fix      = neg_quo_q ? (W'(0) - quo_raw) : quo_raw;
        rem_fix      = neg_rem_q ? (W'(0) - rem_raw) : rem_raw;
    end

    // Next-state and next-output logic; annul outranks every state action.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        if (annul_i && (state_q != S_FREE)) begin
            state_d  = S_FREE;
            cnt_d    = '0;
            ready_d  = 1'b0;
            result_d = '0;
        end else begin
            unique case (state_q)
                S_FREE: begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                    if (start_i && !annul_i) begin
                        work_d    = {W'(0), dividend_mag, 1'b0};
                        divisor_d = divisor_mag;
                        neg_quo_d = signed_div_i && (opdata1_i[W-1] ^ opdata2_i[W-1]);
                        neg_rem_d = signed_div_i && opdata1_i[W-1];
                        state_d   = (opdata2_i == W'(0)) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    // Answer on the second edge after acceptance; cnt marks the first.
                    if (cnt_q == CW'(0)) begin
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d    = '0;
                        result_d = '0;
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
                S_ON: begin
                    if (cnt_q != CW'(W)) begin
                        if (diff[W]) begin
                            work_d = {work_q[2*W-1:0], 1'b0};
                        end else begin
                            work_d = {diff[W-1:0], work_q[W-1:0], 1'b1};
                        end
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        ready_d  = 1'b0;
                        result_d = '0;
                        state_d  = S_FREE;
                    end
                end
                default: begin
                    state_d = S_FREE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
